// File: rtl/matrix_load_ctrl.sv
// Matrix load controller: turns the ASCII digit/separator stream into
// a header (m, n) and m*n row-major element writes for matrix storage.
//
// Ports:
//   sys_clk, sys_rst_n      clock, async active-low reset
//   start                   one-cycle pulse, begins a load (IDLE only)
//   num_valid/num_data      beat strobe and digit value 0-9
//   is_space                beat is a separator (space/CR/LF)
//   wr_en/wr_addr/wr_data   one-cycle element write, addr = i*n + j
//   row_num/col_num         latched m and n
//   busy                    load in progress
//   load_done               pulse one cycle after the last write
//   load_err                sticky error, cleared by the next start
module matrix_load_ctrl #(
    parameter  int DATA_W  = 8,
    parameter  int MAX_DIM = 5,
    parameter  int ADDR_W  = 5,
    localparam int DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              num_valid,
    input  logic [3:0]        num_data,
    input  logic              is_space,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DIM_W-1:0]  row_num,
    output logic [DIM_W-1:0]  col_num,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        IDLE, GET_M, GET_N, GET_ELEM, DONE, ERR
    } state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   acc, acc_d;
    logic                has_digit, has_digit_d;
    logic [ADDR_W-1:0]   elem_cnt, elem_cnt_d;
    logic [DIM_W-1:0]    row_d, col_d;
    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic                load_done_d, load_err_d;

    // Wide enough that acc*10+9 cannot wrap before the range check.
    logic [DATA_W+3:0]   acc_next;
    logic [ADDR_W:0]     total, cnt_inc;
    logic                overflow, dim_bad, last_elem;

    assign acc_next  = {4'b0, acc} * (DATA_W+4)'(10)
                     + (DATA_W+4)'(num_data);
    assign overflow  = acc_next > (DATA_W+4)'(2**DATA_W - 1);
    assign dim_bad   = (acc == '0) || (acc > DATA_W'(MAX_DIM));
    assign total     = (ADDR_W+1)'(row_num) * (ADDR_W+1)'(col_num);
    assign cnt_inc   = {1'b0, elem_cnt} + (ADDR_W+1)'(1);
    assign last_elem = (cnt_inc == total);

    assign busy = (state == GET_M) || (state == GET_N) ||
                  (state == GET_ELEM);

    always_comb begin
        state_d     = state;
        acc_d       = acc;
        has_digit_d = has_digit;
        elem_cnt_d  = elem_cnt;
        row_d       = row_num;
        col_d       = col_num;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        load_done_d = 1'b0;
        load_err_d  = load_err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d     = GET_M;
                    acc_d       = '0;
                    has_digit_d = 1'b0;
                    elem_cnt_d  = '0;
                    load_err_d  = 1'b0;
                end
            end
            GET_M, GET_N, GET_ELEM: begin
                if (num_valid && !is_space) begin
                    if (overflow) begin
                        state_d = ERR;
                    end else begin
                        acc_d       = acc_next[DATA_W-1:0];
                        has_digit_d = 1'b1;
                    end
                end else if (num_valid && has_digit) begin
                    acc_d       = '0;
                    has_digit_d = 1'b0;
                    if (state == GET_ELEM) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = elem_cnt;
                        wr_data_d  = acc;
                        elem_cnt_d = cnt_inc[ADDR_W-1:0];
                        if (last_elem)
                            state_d = DONE;
                    end else if (dim_bad) begin
                        state_d = ERR;
                    end else if (state == GET_M) begin
                        row_d   = acc[DIM_W-1:0];
                        state_d = GET_N;
                    end else begin
                        col_d      = acc[DIM_W-1:0];
                        elem_cnt_d = '0;
                        state_d    = GET_ELEM;
                    end
                end
            end
            // The done pulse is registered so it trails the last write.
            DONE: begin
                load_done_d = 1'b1;
                state_d     = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ERR)
            load_err_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            has_digit <= 1'b0;
            elem_cnt  <= '0;
            row_num   <= '0;
            col_num   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            has_digit <= has_digit_d;
            elem_cnt  <= elem_cnt_d;
            row_num   <= row_d;
            col_num   <= col_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            load_done <= load_done_d;
            load_err  <= load_err_d;
        end
    end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Bench for matrix_load_ctrl: directed and random ASCII streams checked
// against a token-level reference model of the matrix load.
module tb_matrix_load_ctrl;

    localparam int DATA_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int ADDR_W  = 5;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start     = 1'b0;
    logic              num_valid = 1'b0;
    logic [3:0]        num_data  = 4'd0;
    logic              is_space  = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        row_num;
    logic [2:0]        col_num;
    logic              busy;
    logic              load_done;
    logic              load_err;

    matrix_load_ctrl #(
        .DATA_W (DATA_W),
        .MAX_DIM(MAX_DIM),
        .ADDR_W (ADDR_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .num_valid(num_valid),
        .num_data (num_data),
        .is_space (is_space),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .row_num  (row_num),
        .col_num  (col_num),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge sys_clk) cyc++;

    int got_addr[$];
    int got_data[$];
    int done_cnt    = 0;
    int last_wr_cyc = -10;
    int done_cyc    = -20;

    always @(negedge sys_clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            last_wr_cyc = cyc;
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Reference model: token-level view of the load.
    int exp_addr[$];
    int exp_data[$];
    bit exp_done;
    bit exp_err;
    int exp_row = 0;
    int exp_col = 0;

    function automatic bit is_digit(input byte c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic void model(input string s);
        int  ntok = 0;
        int  acc  = 0;
        bit  has  = 0;
        int  m    = 0;
        int  n    = 0;
        int  idx  = 0;
        byte c;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (exp_done || exp_err) break;
            if (is_digit(c)) begin
                acc = acc * 10 + int'(c - "0");
                has = 1;
                if (acc > 255) exp_err = 1;
            end else if (c == " " || c == "\r" || c == "\n") begin
                if (has) begin
                    if (ntok < 2) begin
                        if (acc < 1 || acc > MAX_DIM) begin
                            exp_err = 1;
                        end else if (ntok == 0) begin
                            m = acc;
                            exp_row = acc;
                        end else begin
                            n = acc;
                            exp_col = acc;
                        end
                    end else begin
                        exp_addr.push_back(idx);
                        exp_data.push_back(acc);
                        idx++;
                        if (idx == m * n) exp_done = 1;
                    end
                    ntok++;
                    acc = 0;
                    has = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // '!' in a stream means a start pulse with no beat that cycle.
    task automatic beat(input byte c);
        @(negedge sys_clk);
        if (c == "!") begin
            start     = 1'b1;
            num_valid = 1'b0;
        end else begin
            num_valid = 1'b1;
            is_space  = !is_digit(c);
            num_data  = is_digit(c) ? 4'(c - "0") : 4'd0;
        end
        @(negedge sys_clk);
        start     = 1'b0;
        num_valid = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge sys_clk);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) beat(s[i]);
    endtask

    task automatic pulse_start();
        got_addr.delete();
        got_data.delete();
        done_cnt    = 0;
        last_wr_cyc = -10;
        done_cyc    = -20;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input string s);
        pulse_start();
        send(s);
        repeat (4) @(negedge sys_clk);
        model(s);
        chk({tag, " nwr"}, got_addr.size(), exp_addr.size());
        foreach (exp_addr[i]) begin
            if (i < got_addr.size()) begin
                chk($sformatf("%s addr%0d", tag, i), got_addr[i],
                    exp_addr[i]);
                chk($sformatf("%s data%0d", tag, i), got_data[i],
                    exp_data[i]);
            end
        end
        chk({tag, " done_cnt"}, done_cnt, int'(exp_done));
        if (exp_done)
            chk({tag, " done_lat"}, done_cyc, last_wr_cyc + 1);
        chk({tag, " err"}, load_err, exp_err);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " row"}, row_num, exp_row);
        chk({tag, " col"}, col_num, exp_col);
    endtask

    function automatic string rsep();
        string s = "";
        int    k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
            case ($urandom_range(0, 2))
                0:       s = {s, " "};
                1:       s = {s, "\r"};
                default: s = {s, "\n"};
            endcase
        end
        return s;
    endfunction

    // kind 0: bad dimension, kind 1: overflowing element, else legal.
    function automatic string gen();
        string s    = "";
        int    kind = $urandom_range(0, 3);
        int    m    = $urandom_range(1, 5);
        int    n    = $urandom_range(1, 5);
        int    cnt;
        int    v;
        if (kind == 0)
            m = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(6, 9);
        cnt = (m >= 1 && m <= MAX_DIM) ? m * n : 1;
        s = {s, $sformatf("%0d", m), rsep()};
        s = {s, $sformatf("%0d", n), rsep()};
        for (int k = 0; k < cnt; k++) begin
            v = $urandom_range(0, 255);
            if (kind == 1 && k == cnt - 1) v = $urandom_range(256, 999);
            s = {s, $sformatf("%0d", v), rsep()};
        end
        return s;
    endfunction

    initial begin
        repeat (2) @(negedge sys_clk);
        chk("reset outs",
            {wr_en, wr_addr, wr_data, row_num, col_num,
             busy, load_done, load_err}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        run_load("basic", "2 2 1 23 255 0\n");
        run_load("seps", "1  3\r\n7   8 9 ");
        run_load("ovf", "1 1 256 ");
        run_load("dim0", "0 3 ");
        run_load("dim6", "6 1 ");
        run_load("recover", "1 1 5 ");
        run_load("restart", "2 2 1 23 ! 255 0 ");

        pulse_start();
        send("2 2 4 5 ");
        repeat (3) @(negedge sys_clk);
        chk("pre_rst nwr", got_addr.size(), 2);
        chk("pre_rst busy", busy, 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst outs",
            {wr_en, wr_addr, wr_data, row_num, col_num,
             busy, load_done, load_err}, 0);
        exp_row = 0;
        exp_col = 0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        run_load("post_rst", "1 1 9 ");

        for (int r = 0; r < 8; r++)
            run_load($sformatf("rnd%0d", r), gen());

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_load_ctrl.md
Name: matrix_load_ctrl

Overview:
- Controller that sequences the ASCII-to-digit converter output stream (num_valid / num_data / is_space) into a matrix load.
- Assembles multi-digit decimal tokens, then parses a header of row count m and column count n, followed by m*n elements.
- Issues row-major write strobes into the matrix storage RAM.
- Sits between the UART/ASCII front end and the matrix storage/compute blocks; flags load completion or error.

Parameters:
- DATA_W, 8, element and token width in bits; maximum legal token value is 2^DATA_W-1.
- MAX_DIM, 5, largest legal value of m or n.
- ADDR_W, 5, write address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous reset, active low
- start  input  1  one-cycle pulse; begins a new matrix load
- num_valid  input  1  digit/separator strobe from the ASCII converter
- num_data  input  4  digit value 0-9; meaningful when num_valid=1 and is_space=0
- is_space  input  1  separator (space/CR/LF) qualifier for num_valid
- wr_en  output  1  one-cycle element write strobe
- wr_addr  output  ADDR_W  row-major element index, i*n + j
- wr_data  output  DATA_W  element value
- row_num  output  3  latched m (width ceil(log2(MAX_DIM+1)); 3 at default)
- col_num  output  3  latched n
- busy  output  1  high while a load is in progress
- load_done  output  1  one-cycle pulse when the last element has been written
- load_err  output  1  sticky error flag; cleared by the next start

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Accumulator, has_digit, and element counter cleared.
- States: IDLE, GET_M, GET_N, GET_ELEM, DONE, ERR.
- IDLE:
  - Stream inputs are ignored.
  - start=1: clear acc, has_digit, elem_cnt, load_err; go to GET_M.
  - busy=1 from the cycle after start.
  - Any stream beat in the start cycle is discarded.
- Digit beat (num_valid=1, is_space=0) in GET_M/GET_N/GET_ELEM:
  - acc <= acc*10 + num_data; has_digit <= 1.
  - Compute at DATA_W+4 bits. If the result exceeds 2^DATA_W-1, go to ERR.
- Separator beat (num_valid=1, is_space=1):
  - has_digit=0: ignored (repeated separators, CR+LF).
  - has_digit=1: commit token; clear acc and has_digit.
- Commit in GET_M:
  - Value 0 or >MAX_DIM: go to ERR.
  - Otherwise row_num<=value; go to GET_N.
- Commit in GET_N:
  - Same range check as GET_M.
  - Otherwise col_num<=value; elem_cnt<=0; go to GET_ELEM.
- Commit in GET_ELEM:
  - Next edge: wr_en=1, wr_addr=elem_cnt, wr_data=value (1-cycle latency from the separator beat).
  - elem_cnt increments.
  - If elem_cnt was m*n-1, go to DONE.
- DONE: load_done=1 and busy=0 for exactly one cycle, then IDLE. row_num/col_num hold until the next successful GET_M/GET_N commit.
- ERR:
  - load_err=1 (held); busy=0; no further writes; go to IDLE the next cycle.
  - load_err stays 1 until the next start.
- Other cases:
  - start while busy: ignored.
  - num_valid=0: no state change.
  - Beats after DONE, before the next start: ignored.
  - wr_en is never asserted outside GET_ELEM commits.
  - Reset mid-load: immediate abort; no load_done, no load_err.

Test Plan:
- Stream "2 2 1 23 255 0\n" after start -> wr_en pulses at addr 0,1,2,3 with data 1,23,255,0. row_num=2, col_num=2. load_done pulses once, one cycle after the last write. load_err=0.
- Stream "1  3\r\n7   8 9 " (repeated separators) -> exactly 3 writes, addr 0-2, data 7,8,9. load_done pulses.
- Stream "1 1 256 " -> no wr_en. load_err=1 after the '6' beat. busy=0.
- Header "0 3 " -> load_err=1. Then start + "6 1 " -> load_err=1 (dim > MAX_DIM). Then start + "1 1 5 " -> load_err clears at start, one write of 5, load_done pulses.
- Second start pulse mid-load of "2 2 ..." -> ignored; all 4 elements still write to addr 0-3.
- sys_rst_n low after 2 of 4 elements written -> outputs 0 immediately. Then start + "1 1 9 " -> a single write at addr 0, data 9.
